// File: rtl/alu_seq.sv
// alu_seq: handshaked sequential ALU with registered outputs.
//   Requests (a, b, fxn) are accepted on in_valid && in_ready (IDLE only).
//   Non-MUL functions complete in one cycle. MUL runs a WIDTH-step shift-add.
//   ACC adds a into an internal accumulator that only reset clears.
//   A result is held in DONE with out_valid high until out_ready is seen.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   request handshake; in_ready is a decode of the state
//   a, b, fxn           operands and function select, captured on accept
//   out_valid/out_ready result handshake
//   result, carry, lt, zero  registered result and flags
//   busy                high while the multiplier is iterating
module alu_seq #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       fxn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             lt,
  output logic             zero,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;
  typedef enum logic [2:0] {
    F_ADD = 3'b000, F_SUB = 3'b001, F_AND = 3'b010, F_OR  = 3'b011,
    F_LT  = 3'b100, F_XOR = 3'b101, F_MUL = 3'b110, F_ACC = 3'b111
  } fxn_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               mul_lt_q, mul_lt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_q, carry_d;
  logic               lt_q, lt_d;
  logic               zero_q, zero_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  logic [WIDTH:0]     add_w, sub_w, acc_w;
  logic [2*WIDTH-1:0] mul_step;
  logic [WIDTH-1:0]   res_n;
  logic               cry_n;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;
    mul_lt_d  = mul_lt_q;
    result_d  = result_q;
    carry_d   = carry_q;
    lt_d      = lt_q;
    zero_d    = zero_q;
    res_n     = '0;
    cry_n     = 1'b0;

    add_w    = {1'b0, a} + {1'b0, b};
    // Top bit of the (WIDTH+1)-bit difference is the borrow.
    sub_w    = {1'b0, a} - {1'b0, b};
    acc_w    = {1'b0, acc_q} + {1'b0, a};
    mul_step = prod_q + (mplier_q[0] ? mcand_q : '0);

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (fxn == F_MUL) begin
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            prod_d   = '0;
            cnt_d    = '0;
            mul_lt_d = (a < b);
            state_d  = S_MUL;
          end else begin
            unique case (fxn)
              F_ADD: begin res_n = add_w[WIDTH-1:0]; cry_n = add_w[WIDTH]; end
              F_SUB: begin res_n = sub_w[WIDTH-1:0]; cry_n = sub_w[WIDTH]; end
              F_AND: res_n = a & b;
              F_OR:  res_n = a | b;
              F_XOR: res_n = a ^ b;
              F_LT:  res_n = {{(WIDTH-1){1'b0}}, (a < b)};
              F_ACC: begin
                res_n = acc_w[WIDTH-1:0];
                cry_n = acc_w[WIDTH];
                acc_d = acc_w[WIDTH-1:0];
              end
              default: ;
            endcase
            result_d = res_n;
            carry_d  = cry_n;
            lt_d     = (a < b);
            zero_d   = (res_n == '0);
            state_d  = S_DONE;
          end
        end
      end
      S_MUL: begin
        prod_d   = mul_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        // The last step's sum is loaded straight into the outputs so DONE
        // is entered exactly WIDTH cycles after accept.
        if (cnt_q == LAST_STEP) begin
          cnt_d    = '0;
          result_d = mul_step[WIDTH-1:0];
          carry_d  = |mul_step[2*WIDTH-1:WIDTH];
          lt_d     = mul_lt_q;
          zero_d   = (mul_step[WIDTH-1:0] == '0);
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d == S_MUL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
      mul_lt_q    <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      lt_q        <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      prod_q      <= prod_d;
      cnt_q       <= cnt_d;
      mul_lt_q    <= mul_lt_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      lt_q        <= lt_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign lt        = lt_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq: directed steps from the block's test plan followed by
// random operations, each checked against an arithmetic reference model.
module tb_alu_seq;

  localparam int W = 6;
  localparam int unsigned MOD = 1 << W;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic [2:0]   fxn;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry, lt, zero, busy;

  int errors = 0;
  int checks = 0;
  int unsigned model_acc = 0;

  typedef struct {
    int unsigned res;
    bit          cry;
    bit          lt;
    bit          zero;
  } exp_t;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .fxn(fxn), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .lt(lt), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain arithmetic on integers, modulo 2^W.
  function automatic exp_t model(input int unsigned f, input int unsigned x,
                                 input int unsigned y, input int unsigned acc);
    exp_t e;
    int unsigned s;
    e.cry = 1'b0;
    e.lt  = (x < y);
    case (f)
      0: begin s = x + y; e.res = s % MOD; e.cry = (s >= MOD); end
      1: begin e.res = (x + MOD - y) % MOD; e.cry = (x < y); end
      2: e.res = x & y;
      3: e.res = x | y;
      4: e.res = (x < y) ? 1 : 0;
      5: e.res = x ^ y;
      6: begin s = x * y; e.res = s % MOD; e.cry = (s >= MOD); end
      default: begin s = acc + x; e.res = s % MOD; e.cry = (s >= MOD); end
    endcase
    e.zero = (e.res == 0);
    return e;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_acc = 0;
  endtask

  // Issue one request, follow it through to DONE and check the result.
  // With out_ready high, also checks the release back to IDLE.
  task automatic run_op(input int unsigned f, input int unsigned x, input int unsigned y);
    exp_t e;
    int n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    chk("ready_wait", in_ready, 1);
    in_valid = 1'b1;
    fxn = 3'(f);
    a = W'(x);
    b = W'(y);
    step();
    in_valid = 1'b0;
    a = '1;
    b = '1;
    fxn = 3'b000;
    e = model(f, x, y, model_acc);
    if (f == 7) model_acc = e.res;
    chk("in_ready_after_accept", in_ready, 0);
    if (f == 6) begin
      for (int i = 0; i < W; i++) begin
        chk("mul_busy", busy, 1);
        chk("mul_no_valid", out_valid, 0);
        step();
      end
    end
    chk("out_valid", out_valid, 1);
    chk("busy_done", busy, 0);
    chk("result", result, e.res);
    chk("carry", carry, e.cry);
    chk("lt", lt, e.lt);
    chk("zero", zero, e.zero);
    if (out_ready) begin
      step();
      chk("release_valid", out_valid, 0);
      chk("release_ready", in_ready, 1);
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    fxn = 3'b000;
    out_ready = 1'b1;
    step();
    step();
    reset = 1'b0;
    model_acc = 0;

    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_carry", carry, 0);
    chk("rst_lt", lt, 0);
    chk("rst_zero", zero, 0);

    run_op(0, 63, 1);
    run_op(1, 3, 4);
    run_op(4, 3, 1);
    run_op(5, 3, 1);
    run_op(6, 5, 7);
    run_op(6, 9, 8);
    run_op(7, 40, 0);
    run_op(7, 30, 0);
    do_reset();
    run_op(7, 1, 0);

    // Back-pressure: result held, new requests ignored while in DONE.
    out_ready = 1'b0;
    run_op(0, 2, 2);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      fxn = 3'b000;
      a = 7;
      b = 7;
      step();
      chk("bp_valid", out_valid, 1);
      chk("bp_result", result, 4);
      chk("bp_ready", in_ready, 0);
    end
    // Release with in_valid still high: must not be accepted from DONE.
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_ready", in_ready, 1);
    chk("bp_release_result", result, 4);
    step();
    chk("bp_no_accept", out_valid, 0);

    // Reset in the middle of a multiply discards it.
    in_valid = 1'b1;
    fxn = 3'b110;
    a = 63;
    b = 63;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    do_reset();
    chk("mrst_ready", in_ready, 1);
    chk("mrst_valid", out_valid, 0);
    chk("mrst_busy", busy, 0);
    for (int i = 0; i < W + 2; i++) begin
      step();
      chk("mrst_no_result", out_valid, 0);
    end
    run_op(0, 1, 1);

    // Random operations, occasionally with back-pressure.
    for (int i = 0; i < 40; i++) begin
      int unsigned f, x, y, hold;
      f = $urandom_range(0, 7);
      x = $urandom_range(0, MOD - 1);
      y = $urandom_range(0, MOD - 1);
      hold = $urandom_range(0, 3);
      out_ready = (hold != 0);
      run_op(f, x, y);
      if (hold == 0) begin
        step();
        chk("rnd_hold_valid", out_valid, 1);
        out_ready = 1'b1;
        step();
        chk("rnd_hold_release", out_valid, 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
